// File: rtl/serial_pkg.sv
// Shared types and default constants for the dice roller's serial receive path.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int CYCLES_PER_BIT_DEF = 10;
  localparam int DATA_BITS_DEF      = 7;

endpackage

// File: rtl/rx_shift_reg.sv
// Receive shift register: each strobe shifts the sampled bit in at the MSB, so an
// LSB-first frame ends up right-aligned after DATA_BITS strobes.
module rx_shift_reg
  import serial_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear_i,
  input  logic                 shift_i,
  input  logic                 bit_i,
  output logic [DATA_BITS-1:0] word_o
);

  logic [DATA_BITS-1:0] word_q;

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q <= '0;
    end else if (clear_i) begin
      word_q <= '0;
    end else if (shift_i) begin
      word_q <= {bit_i, word_q[DATA_BITS-1:1]};
    end
  end

  assign word_o = word_q;

endmodule

// File: rtl/serial_rx_ctrl.sv
// Serial receive controller: synchronizer, start/data/stop FSM with mid-bit sampling,
// and a valid/ready output register that flags framing errors and overruns.
module serial_rx_ctrl
  import serial_pkg::*;
#(
  parameter int CYCLES_PER_BIT = CYCLES_PER_BIT_DEF,
  parameter int DATA_BITS      = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_rx,
  input  logic                 i_ready,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_busy,
  output logic                 o_frame_err,
  output logic                 o_overrun
);

  localparam int CNT_W = $clog2(CYCLES_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CYCLES_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

  rx_state_e            state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [BIT_W-1:0]     bit_cnt_q;
  logic                 rx_meta_q, rx_s_q, rx_d_q;
  logic                 busy_q, valid_q, frame_err_q, overrun_q;
  logic [DATA_BITS-1:0] data_q;
  logic [DATA_BITS-1:0] word;
  logic                 shift_en, shift_clr;

  // The line idles high, so the synchronizer resets to 1 to avoid a phantom start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_d_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
      rx_d_q    <= rx_s_q;
    end
  end

  assign shift_en  = (state_q == DATA)  && (cnt_q == BIT_LAST);
  assign shift_clr = (state_q == START) && (cnt_q == HALF_LAST) && !rx_s_q;

  rx_shift_reg #(.DATA_BITS(DATA_BITS)) u_shift (
    .clk    (clk),
    .reset  (reset),
    .clear_i(shift_clr),
    .shift_i(shift_en),
    .bit_i  (rx_s_q),
    .word_o (word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      busy_q      <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      // A load later in this block overrides the consume-clear when both happen at once.
      if (valid_q && i_ready) valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (rx_d_q && !rx_s_q) begin
            state_q <= START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            if (!rx_s_q) begin
              state_q <= DATA;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q     <= '0;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_BIT) state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (!rx_s_q) begin
              frame_err_q <= 1'b1;
            end else if (!valid_q || i_ready) begin
              data_q  <= word;
              valid_q <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_busy      = busy_q;
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_serial_rx_ctrl.sv
// Bench for serial_rx_ctrl: table-driven frames plus hand sequences for glitch,
// overrun, simultaneous accept/load and mid-frame reset, checked via a timed scoreboard.
module tb_serial_rx_ctrl;
  import serial_pkg::*;

  localparam int CPB = 10;
  localparam int DB  = 7;
  // From driving the start bit: 2 synchronizer cycles to T0, then the frame time to o_valid.
  localparam int LAT = 2 + CPB / 2 + (DB + 1) * CPB + 1;
  localparam int FRAME_CYC = (DB + 2) * CPB;

  logic          clk = 1'b0;
  logic          reset, i_rx, i_ready;
  logic [DB-1:0] o_data;
  logic          o_valid, o_busy, o_frame_err, o_overrun;

  serial_rx_ctrl #(.CYCLES_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_rx       (i_rx),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_busy     (o_busy),
    .o_frame_err(o_frame_err),
    .o_overrun  (o_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        valid;
    logic [DB-1:0] data;
    logic        chk_data;
    logic        ferr;
    logic        ovr;
  } exp_t;

  typedef struct {
    logic [DB-1:0] data;
    logic          stop;
    logic          exp_valid;
    logic [DB-1:0] exp_data;
    logic          exp_ferr;
  } vec_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_vec  = 0;
  int   n_fail = 0;
  logic prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drives one full frame; optionally pulses i_ready at a given offset or asserts reset mid-frame.
  task automatic frame(input logic [DB-1:0] data, input logic stop, input bit push,
                       input exp_t e, input int ready_at, input int abort_at);
    logic [DB+1:0] fb;
    exp_t          ex;
    fb = {stop, data, 1'b0};
    ex = e;
    for (int t = 0; t < FRAME_CYC; t++) begin
      @(negedge clk);
      if (t == 0 && push) begin
        ex.cyc = cyc + LAT;
        sbq.push_back(ex);
      end
      if (abort_at < 0) begin
        if (t == 2)       check("busy_low_at_t0", o_busy, 1'b0);
        if (t == 3)       check("busy_rise", o_busy, 1'b1);
        if (t == LAT - 1) check("busy_stop_sample", o_busy, 1'b1);
        if (t == LAT)     check("busy_fall", o_busy, 1'b0);
      end
      if (t == abort_at) begin
        check("busy_before_reset", o_busy, 1'b1);
        check("valid_before_reset", o_valid, 1'b1);
        reset = 1'b1;
        #1;
        check("reset_busy", o_busy, 1'b0);
        check("reset_valid", o_valid, 1'b0);
        check("reset_data", o_data, 7'h00);
        return;
      end
      if (t == ready_at) i_ready = 1'b1;
      else if (t == ready_at + 1) i_ready = 1'b0;
      i_rx = fb[t / CPB];
    end
    i_rx = 1'b1;
  endtask

  task automatic consume();
    @(negedge clk);
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    check("accept_clears_valid", o_valid, 1'b0);
  endtask

  // Scoreboard monitor: compares scheduled events at their cycle, flags anything unscheduled.
  always @(negedge clk) begin
    if (!reset) begin
      if (sbq.size() != 0 && sbq[0].cyc == cyc) begin
        mon_e = sbq.pop_front();
        check("sb_valid", o_valid, mon_e.valid);
        if (mon_e.chk_data) check("sb_data", o_data, mon_e.data);
        check("sb_frame_err", o_frame_err, mon_e.ferr);
        check("sb_overrun", o_overrun, mon_e.ovr);
      end else begin
        if (o_frame_err || o_overrun) check("stray_flag", {o_frame_err, o_overrun}, 2'b00);
        if (o_valid && !prev_valid)   check("stray_valid", o_valid, 1'b0);
      end
    end
    prev_valid <= o_valid;
  end

  vec_t vt[7];
  exp_t e;

  initial begin
    vt[0] = '{7'h55, 1'b1, 1'b1, 7'h55, 1'b0};
    vt[1] = '{7'h2A, 1'b0, 1'b0, 7'h00, 1'b1};
    vt[2] = '{7'h00, 1'b1, 1'b1, 7'h00, 1'b0};
    vt[3] = '{7'h7F, 1'b1, 1'b1, 7'h7F, 1'b0};
    vt[4] = '{7'h01, 1'b1, 1'b1, 7'h01, 1'b0};
    vt[5] = '{7'h40, 1'b1, 1'b1, 7'h40, 1'b0};
    vt[6] = '{7'h2A, 1'b0, 1'b0, 7'h00, 1'b1};

    reset = 1'b1; i_rx = 1'b1; i_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", o_valid, 1'b0);
    check("rst_data", o_data, 7'h00);
    check("rst_busy", o_busy, 1'b0);
    check("rst_frame_err", o_frame_err, 1'b0);
    check("rst_overrun", o_overrun, 1'b0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Glitch: 3-cycle low pulse is a false start with no flags.
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (t == 3) check("glitch_busy", o_busy, 1'b1);
      if (t == 8) check("glitch_idle", o_busy, 1'b0);
      i_rx = (t < 3) ? 1'b0 : 1'b1;
    end

    for (int i = 0; i < 7; i++) begin
      e.valid    = vt[i].exp_valid;
      e.data     = vt[i].exp_data;
      e.chk_data = vt[i].exp_valid;
      e.ferr     = vt[i].exp_ferr;
      e.ovr      = 1'b0;
      frame(vt[i].data, vt[i].stop, 1'b1, e, -5, -1);
      repeat (2) @(negedge clk);
      if (vt[i].exp_valid) consume();
      else check("ferr_no_valid", o_valid, 1'b0);
    end

    // Overrun: second good frame while the first is unconsumed.
    e = '{0, 1'b1, 7'h11, 1'b1, 1'b0, 1'b0};
    frame(7'h11, 1'b1, 1'b1, e, -5, -1);
    e = '{0, 1'b1, 7'h11, 1'b1, 1'b0, 1'b1};
    frame(7'h22, 1'b1, 1'b1, e, -5, -1);
    check("overrun_keeps_data", o_data, 7'h11);
    consume();

    // Accept and load in the same cycle.
    e = '{0, 1'b1, 7'h33, 1'b1, 1'b0, 1'b0};
    frame(7'h33, 1'b1, 1'b1, e, -5, -1);
    e = '{0, 1'b1, 7'h7F, 1'b1, 1'b0, 1'b0};
    frame(7'h7F, 1'b1, 1'b1, e, LAT - 1, -1);
    check("simul_valid_held", o_valid, 1'b1);

    // Reset during data bit 3 with a word still pending, then a clean frame.
    frame(7'h55, 1'b1, 1'b0, e, -5, 2 + CPB / 2 + 4 * CPB - 2);
    i_rx = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    e = '{0, 1'b1, 7'h01, 1'b1, 1'b0, 1'b0};
    frame(7'h01, 1'b1, 1'b1, e, -5, -1);
    consume();

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
